// File: rtl/quad_encoder.sv
// -----------------------------------------------------------------------------
// quad_encoder
//   Quadrature decoder for the motor shaft encoder. Each incoming channel
//   passes through a two-flop synchroniser and a run-length glitch filter.
//   The filtered A/B pair is decoded into a signed position count, a
//   direction flag and an illegal-transition counter.
//
//   The inputs and outputs have no handshake. encoder_count, enc_dir and
//   error_count are level outputs that are valid in every cycle.
//   illegal_step is a single-cycle strobe, and there is no back-pressure.
//
//   Optional feature: define ENCODER_INDEX_EN to add the index channel
//   (enc_i). A rising edge of the filtered index level captures the position
//   into index_count and sets the sticky index_seen flag.
// -----------------------------------------------------------------------------
module quad_encoder #(
   parameter int FILTER_LEN  = 4,   // accepted after this many stable samples (1..255)
   parameter int COUNT_WIDTH = 64   // two's complement position width
) (
   input  logic                   CLK,
   input  logic                   resetn,
   input  logic                   enc_a,
   input  logic                   enc_b,
`ifdef ENCODER_INDEX_EN
   input  logic                   enc_i,
`endif
   input  logic                   clear,
   output logic [COUNT_WIDTH-1:0] encoder_count,
   output logic                   enc_dir,
   output logic                   illegal_step,
   output logic [7:0]             error_count
`ifdef ENCODER_INDEX_EN
   ,
   output logic [COUNT_WIDTH-1:0] index_count,
   output logic                   index_seen
`endif
);

   // Channel numbering inside the shared sync/filter arrays.
   localparam int CH_A = 0;
   localparam int CH_B = 1;
`ifdef ENCODER_INDEX_EN
   localparam int CH_I = 2;
   localparam int NCH  = 3;
`else
   localparam int NCH  = 2;
`endif

   // The filter counter resets when the sample returns to the accepted level.
   // The channel accepts the new level on its FILTER_LEN-th consecutive
   // differing sample.
   localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

   // Priming waits for FILTER_LEN + 2 quiet samples. The two extra samples
   // cover the synchroniser flops, which hold reset zeros rather than genuine
   // input samples just after reset. This keeps a non-zero resting level from
   // being decoded as a step once priming is done.
   localparam logic [8:0] PRIME_LAST = 9'(FILTER_LEN + 1);

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   // ---------------------------------------------------------------------------
   // Input gathering
   // ---------------------------------------------------------------------------
   logic [NCH-1:0] raw;

`ifdef ENCODER_INDEX_EN
   assign raw = {enc_i, enc_b, enc_a};
`else
   assign raw = {enc_b, enc_a};
`endif

   // ---------------------------------------------------------------------------
   // Synchroniser
   // ---------------------------------------------------------------------------
   logic [NCH-1:0] sync1;
   logic [NCH-1:0] sync2;

   // Two-flop synchroniser per channel; sync2 is the first usable sample.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // ---------------------------------------------------------------------------
   // Glitch filter
   // ---------------------------------------------------------------------------
   logic [NCH-1:0] acc;
   logic [NCH-1:0] acc_nx;
   logic [7:0]     filt_cnt    [NCH];
   logic [7:0]     filt_cnt_nx [NCH];

   // Per-channel run-length filter: count consecutive samples that differ from
   // the accepted level, and accept the level when the run reaches FILTER_LEN.
   always_comb begin
      acc_nx = acc;
      for (int c = 0; c < NCH; c++) begin
         filt_cnt_nx[c] = '0;
         if (sync2[c] != acc[c]) begin
            if (filt_cnt[c] == FILT_LAST) begin
               acc_nx[c] = sync2[c];
            end else begin
               filt_cnt_nx[c] = filt_cnt[c] + 8'd1;
            end
         end
      end
   end

   // Filter state registers.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         acc <= '0;
         for (int c = 0; c < NCH; c++) begin
            filt_cnt[c] <= '0;
         end
      end else begin
         acc <= acc_nx;
         for (int c = 0; c < NCH; c++) begin
            filt_cnt[c] <= filt_cnt_nx[c];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Priming
   // ---------------------------------------------------------------------------
   logic       primed;
   logic [8:0] prime_cnt;
   logic       quiet_ab;
   logic       prime_load;

   assign quiet_ab   = (sync2[CH_A] == acc[CH_A]) && (sync2[CH_B] == acc[CH_B]);
   assign prime_load = !primed && quiet_ab && (prime_cnt == PRIME_LAST);

   // Wait until both A and B have rested at their accepted levels long enough,
   // then arm the decoder. Any disturbance before then restarts the wait.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         primed    <= 1'b0;
         prime_cnt <= '0;
      end else if (!primed) begin
         if (!quiet_ab) begin
            prime_cnt <= '0;
         end else if (prime_cnt == PRIME_LAST) begin
            primed <= 1'b1;
         end else begin
            prime_cnt <= prime_cnt + 9'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   logic [1:0]             curr_ab;
   logic [1:0]             prev_ab;
   logic                   ab_moved;
   logic                   step_fwd;
   logic                   step_rev;
   logic                   step_bad;
   logic [COUNT_WIDTH-1:0] count_nx;

   assign curr_ab  = {acc[CH_A], acc[CH_B]};
   assign ab_moved = primed && (curr_ab != prev_ab);

   // Classify the {prev,curr} pair of the filtered {A,B}. Both bits changing
   // in the same cycle cannot be assigned a direction, so it is illegal.
   always_comb begin
      step_fwd = 1'b0;
      step_rev = 1'b0;
      step_bad = 1'b0;
      if (ab_moved) begin
         case ({prev_ab, curr_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_fwd = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_rev = 1'b1;
            default:                                step_bad = 1'b1;
         endcase
      end
   end

   // Next position: clear overrides any step that lands in the same cycle,
   // and the arithmetic wraps naturally at COUNT_WIDTH bits.
   always_comb begin
      count_nx = encoder_count;
      if (clear) begin
         count_nx = '0;
      end else if (step_fwd) begin
         count_nx = encoder_count + CNT_ONE;
      end else if (step_rev) begin
         count_nx = encoder_count - CNT_ONE;
      end
   end

   // Decode register: position, direction, illegal strobe and error tally.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         prev_ab       <= 2'b00;
         encoder_count <= '0;
         enc_dir       <= 1'b0;
         illegal_step  <= 1'b0;
         error_count   <= 8'd0;
      end else begin
         encoder_count <= count_nx;
         illegal_step  <= step_bad;
         if (step_fwd) begin
            enc_dir <= 1'b1;
         end else if (step_rev) begin
            enc_dir <= 1'b0;
         end
         if (step_bad && (error_count != 8'hFF)) begin
            error_count <= error_count + 8'd1;
         end
         if (prime_load || ab_moved) begin
            prev_ab <= curr_ab;
         end
      end
   end

`ifdef ENCODER_INDEX_EN
   // ---------------------------------------------------------------------------
   // Index capture
   // ---------------------------------------------------------------------------
   logic i_prev;
   logic i_rise;

   assign i_rise = acc[CH_I] && !i_prev;

   // Latch the post-update position on a rising filtered index; clear wipes it.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         i_prev      <= 1'b0;
         index_count <= '0;
         index_seen  <= 1'b0;
      end else begin
         i_prev <= acc[CH_I];
         if (clear) begin
            index_count <= '0;
            index_seen  <= 1'b0;
         end else if (i_rise) begin
            index_count <= count_nx;
            index_seen  <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_quad_encoder.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder
//   Randomised bench for quad_encoder with an expected-event queue.
//
//   The drivers update a rotary-wheel model of the encoder. For every change
//   the DUT must show, they push the expected outputs and the cycle in which
//   the outputs must appear. A separate monitor pops the queue whenever the
//   DUT outputs move and compares the popped entry against them.
// -----------------------------------------------------------------------------
module tb_quad_encoder;
  localparam int FL    = 4;
  localparam int CW    = 64;
  localparam int EXP_W = 32 + CW + 1 + 1 + 8;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          enc_a;
  logic          enc_b;
  logic          clear;
  logic [CW-1:0] encoder_count;
  logic          enc_dir;
  logic          illegal_step;
  logic [7:0]    error_count;
`ifdef ENCODER_INDEX_EN
  logic          enc_i;
  logic [CW-1:0] index_count;
  logic          index_seen;
`endif

  quad_encoder #(.FILTER_LEN(FL), .COUNT_WIDTH(CW)) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .enc_a         (enc_a),
    .enc_b         (enc_b),
`ifdef ENCODER_INDEX_EN
    .enc_i         (enc_i),
    .index_count   (index_count),
    .index_seen    (index_seen),
`endif
    .clear         (clear),
    .encoder_count (encoder_count),
    .enc_dir       (enc_dir),
    .illegal_step  (illegal_step),
    .error_count   (error_count)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               mon_en  = 1'b0;

  // Reference model: the wheel position in {A,B} and the outputs it implies.
  logic [1:0]    m_ab;
  logic [CW-1:0] m_cnt;
  logic          m_dir;
  logic [7:0]    m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Forward rotation visits {A,B} = 00, 10, 11, 01 in that order.
  function automatic int wheel_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] wheel_at(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic push_event(input int at_cyc, input logic ill);
    exp_q.push_back({32'(at_cyc), m_cnt, m_dir, ill, m_err});
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  // Move the encoder inputs to ab. With with_clear set, clear is pulsed into
  // the cycle in which the step is decoded; the caller ensures an observable
  // change results (non-zero count beforehand).
  task automatic move_to(input logic [1:0] ab, input bit with_clear);
    int d;
    int t0;
    d  = (wheel_pos(ab) - wheel_pos(m_ab) + 4) % 4;
    t0 = cyc;
    enc_a = ab[1];
    enc_b = ab[0];
    if (d == 1) begin
      m_cnt = m_cnt + 64'd1;
      m_dir = 1'b1;
    end else if (d == 3) begin
      m_cnt = m_cnt - 64'd1;
      m_dir = 1'b0;
    end else if (d == 2 && m_err != 8'd255) begin
      m_err = m_err + 8'd1;
    end
    if (with_clear) m_cnt = '0;
    m_ab = ab;
    if (d != 0) push_event(t0 + FL + 3, d == 2);
    if (with_clear) begin
      while (cyc < t0 + FL + 2) @(negedge CLK);
      clear = 1'b1;
      @(negedge CLK);
      clear = 1'b0;
    end
  endtask

  task automatic step(input bit fwd, input bit with_clear);
    move_to(wheel_at(wheel_pos(m_ab) + (fwd ? 1 : 3)), with_clear);
  endtask

  task automatic illegal_toggle();
    move_to(~m_ab, 1'b0);
  endtask

  task automatic glitch(input int ch, input int len);
    if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
    repeat (len) @(negedge CLK);
    if (ch == 0) enc_a = ~enc_a; else enc_b = ~enc_b;
  endtask

  task automatic do_clear();
    int t0;
    t0 = cyc;
    clear = 1'b1;
    if (m_cnt != '0) begin
      m_cnt = '0;
      push_event(t0 + 1, 1'b0);
    end
    @(negedge CLK);
    clear = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(FL + 4, FL + 10)) @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  logic [CW-1:0] last_cnt = '0;
  logic          last_dir = 1'b0;
  logic [7:0]    last_err = 8'd0;

  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (encoder_count !== last_cnt || enc_dir !== last_dir ||
            illegal_step !== 1'b0 || error_count !== last_err) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got count %0h dir %0b ill %0b err %0d, required no change (cycle %0d)",
                     encoder_count, enc_dir, illegal_step, error_count, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
            check("encoder_count", encoder_count, e[CW+9:10]);
            check("enc_dir", 64'(enc_dir), 64'(e[9]));
            check("illegal_step", 64'(illegal_step), 64'(e[8]));
            check("error_count", 64'(error_count), 64'(e[7:0]));
          end
        end
        last_cnt = encoder_count;
        last_dir = enc_dir;
        last_err = error_count;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    enc_a  = 1'b0;
    enc_b  = 1'b0;
    clear  = 1'b0;
`ifdef ENCODER_INDEX_EN
    enc_i  = 1'b0;
`endif
    m_ab = 2'b00; m_cnt = '0; m_dir = 1'b0; m_err = 8'd0;

    repeat (3) @(negedge CLK);
    check("reset_count", encoder_count, 64'd0);
    check("reset_dir", 64'(enc_dir), 64'd0);
    check("reset_illegal", 64'(illegal_step), 64'd0);
    check("reset_errors", 64'(error_count), 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge CLK);

    // Four forward steps from rest at 00.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      repeat (10) @(negedge CLK);
    end
    drain();
    check("fwd4_count", encoder_count, 64'd4);
    check("fwd4_dir", 64'(enc_dir), 64'd1);
    check("fwd4_errors", 64'(error_count), 64'd0);

    // 00 -> 11 and back: two illegal transitions.
    illegal_toggle(); gap();
    illegal_toggle(); gap();

    // Reverse from zero wraps to all ones.
    do_clear(); gap();
    step(1'b0, 1'b0); gap();
    drain();
    check("wrap_count", encoder_count, 64'hFFFF_FFFF_FFFF_FFFF);

    // Short pulses are rejected; a full-length hold is one step (latency checked by the monitor).
    glitch(0, FL - 1); gap();
    glitch(1, 1); gap();
    move_to({~m_ab[1], m_ab[0]}, 1'b0); gap();

    // Clear coinciding with accepted steps.
    do_clear(); gap();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0); gap();
    end
    step(1'b1, 1'b1); gap();
    step(1'b1, 1'b0); gap();
    step(1'b1, 1'b0); gap();
    step(1'b0, 1'b1); gap();
    drain();
    check("clear_rev_dir", 64'(enc_dir), 64'd0);

    // Random mix.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    step(1'b1, 1'b0);
        2:       step(1'b0, 1'b0);
        3:       illegal_toggle();
        4:       glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, FL - 1)));
        default: do_clear();
      endcase
      gap();
    end

    // Error counter saturation.
    for (int i = 0; i < 256; i++) begin
      illegal_toggle();
      repeat (FL + 4) @(negedge CLK);
    end
    drain();
    check("err_saturated", 64'(error_count), 64'd255);

    // Mid-run reset with inputs parked at 11.
    mon_en = 1'b0;
    resetn = 1'b0;
    enc_a  = 1'b1;
    enc_b  = 1'b1;
    #1;
    check("midreset_count", encoder_count, 64'd0);
    check("midreset_dir", 64'(enc_dir), 64'd0);
    check("midreset_illegal", 64'(illegal_step), 64'd0);
    check("midreset_errors", 64'(error_count), 64'd0);
`ifdef ENCODER_INDEX_EN
    check("midreset_index_count", index_count, 64'd0);
    check("midreset_index_seen", 64'(index_seen), 64'd0);
`endif
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    m_ab = 2'b11; m_cnt = '0; m_dir = 1'b0; m_err = 8'd0;
    last_cnt = '0; last_dir = 1'b0; last_err = 8'd0;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (40) @(negedge CLK);
    check("reprime_count", encoder_count, 64'd0);
    step(1'b1, 1'b0); gap();

`ifdef ENCODER_INDEX_EN
    do_clear(); gap();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0); gap();
    end
    enc_i = 1'b1;
    repeat (FL + 6) @(negedge CLK);
    check("index_count", index_count, m_cnt);
    check("index_seen", 64'(index_seen), 64'd1);
    do_clear(); gap();
    check("index_cleared_count", index_count, 64'd0);
    check("index_cleared_seen", 64'(index_seen), 64'd0);
`endif

    drain();
    repeat (FL + 10) @(negedge CLK);
    check("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete, required completion before %0d cycles", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
